// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, default byte width
// and a ceiling-log2 helper used by both the transmit and receive paths.
package uart_pkg;

   // Default character width of the link.
   localparam int UART_BYTE_W = 8;

   // Transmit-side handshake states.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } uart_tx_state_e;

   // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array for the transmit FIFO. Synchronous write
// port, asynchronous read port so the FSM can capture the head byte in the
// same cycle it decides to pop. Storage is not reset; occupancy is tracked
// by the owner of the pointers.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = UART_BYTE_W
) (
   input  logic                      clk_i,
   input  logic                      we_i,
   input  logic [clog2(DEPTH)-1:0]   waddr_i,
   input  logic [WIDTH-1:0]          wdata_i,
   input  logic [clog2(DEPTH)-1:0]   raddr_i,
   output logic [WIDTH-1:0]          rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port: store the incoming byte at the write pointer.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the processing block and the UART transmitter.
// Queues bytes while the transmitter is busy and releases one per frame
// using a one-cycle tx_start pulse and the tx_ready handshake.
// Optional build macro UART_TX_FIFO_HWM_EN adds a high-water mark output
// (high_water) and its clear input (hwm_clear).
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int WIDTH        = UART_BYTE_W,
   parameter int BUSY_TIMEOUT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_valid,
   input  logic [WIDTH-1:0]        wr_data,
   output logic                    full,
   output logic                    empty,
   output logic [clog2(DEPTH):0]   count,
   output logic                    overflow,
   input  logic                    tx_ready,
   output logic                    tx_start,
   output logic [WIDTH-1:0]        tx_data
`ifdef UART_TX_FIFO_HWM_EN
   ,
   input  logic                    hwm_clear,
   output logic [clog2(DEPTH):0]   high_water
`endif
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = clog2(BUSY_TIMEOUT) + 1;

   localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BUSY_TIMEOUT - 1);

   uart_tx_state_e     state_q, state_d;
   logic [AW-1:0]      wptr_q, wptr_d;
   logic [AW-1:0]      rptr_q, rptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               overflow_q, overflow_d;
   logic [WIDTH-1:0]   tx_data_q, tx_data_d;
   logic [TW-1:0]      timer_q, timer_d;

   logic               full_w;
   logic               empty_w;
   logic               push;
   logic               pop;
   logic [WIDTH-1:0]   rd_data;

   assign full_w  = (count_q == DEPTH_C);
   assign empty_w = (count_q == '0);

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (push),
      .waddr_i (wptr_q),
      .wdata_i (wr_data),
      .raddr_i (rptr_q),
      .rdata_o (rd_data)
   );

   // Transmit handshake: capture head byte, pulse start, wait for the
   // transmitter to go busy (or give up after BUSY_TIMEOUT), then wait idle.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty_w && tx_ready) begin
               pop       = 1'b1;
               tx_data_d = rd_data;
               state_d   = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            timer_d = '0;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (!tx_ready) begin
               state_d = ST_WAIT_DONE;
            end else if (timer_q == TIMEOUT_LAST) begin
               // Transmitter never acknowledged; treat the byte as sent.
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (tx_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Pointer, occupancy and overflow bookkeeping. A write into a full FIFO
   // is still accepted when the head is leaving in the same cycle.
   always_comb begin
      push       = wr_valid && (!full_w || pop);
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      overflow_d = overflow_q;
      if (push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      if (wr_valid && !push) begin
         overflow_d = 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // Control and held-byte registers; reset discards queued and held bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tx_data_q  <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tx_data_q  <= tx_data_d;
         timer_q    <= timer_d;
      end
   end

   assign full     = full_w;
   assign empty    = empty_w;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign tx_start = (state_q == ST_LAUNCH);
   assign tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_HWM_EN
   logic [CW-1:0] hwm_q, hwm_d;

   // High-water tracking follows the occupancy value being registered this
   // edge; a clear restarts tracking from that occupancy.
   always_comb begin
      hwm_d = hwm_q;
      if (hwm_clear) begin
         hwm_d = count_d;
      end else if (count_d > hwm_q) begin
         hwm_d = count_d;
      end
   end

   // High-water register.
   always_ff @(posedge clk) begin
      if (rst) begin
         hwm_q <= '0;
      end else begin
         hwm_q <= hwm_d;
      end
   end

   assign high_water = hwm_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16, BUSY_TIMEOUT=4).
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic       tx_ready;
   logic       tx_start;
   logic [7:0] tx_data;
`ifdef UART_TX_FIFO_HWM_EN
   logic       hwm_clear;
   logic [4:0] high_water;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] launches[$];

   uart_tx_fifo #(
      .DEPTH        (16),
      .WIDTH        (8),
      .BUSY_TIMEOUT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .full       (full),
      .empty      (empty),
      .count      (count),
      .overflow   (overflow),
      .tx_ready   (tx_ready),
      .tx_start   (tx_start),
      .tx_data    (tx_data)
`ifdef UART_TX_FIFO_HWM_EN
      ,
      .hwm_clear  (hwm_clear),
      .high_water (high_water)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every byte launched to the transmitter, sampled mid-cycle.
   always @(negedge clk) begin
      if (tx_start === 1'b1) launches.push_back(tx_data);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      tx_ready = 1'b0;
`ifdef UART_TX_FIFO_HWM_EN
      hwm_clear = 1'b0;
`endif
      repeat (2) tick();
      rst = 1'b0;
      launches.delete();
   endtask

   // Transmitter emulation: wait for each start pulse (bounded), then either
   // go busy for 'busy' cycles or, with busy=0, never acknowledge.
   task automatic run_tx(input int nframes, input int busy, output int seen);
      int wait_cnt;
      seen     = 0;
      tx_ready = 1'b1;
      for (int f = 0; f < nframes; f++) begin
         wait_cnt = 0;
         while (tx_start !== 1'b1 && wait_cnt < 40) begin
            tick();
            wait_cnt++;
         end
         if (tx_start !== 1'b1) return;
         seen++;
         if (busy > 0) begin
            tx_ready = 1'b0;
            repeat (busy) tick();
            tx_ready = 1'b1;
         end else begin
            tick();
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
`ifdef UART_TX_FIFO_HWM_EN
      n_checks++; if (high_water !== 5'd0) begin n_fail++; $display("FAIL reset_hwm: got %0d expected 0", high_water); end
`endif
   endtask

   task automatic test_single_byte();
      do_reset();
      tx_ready = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h41;
      tick();
      wr_valid = 1'b0;
      n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL single_count_n1: got %0d expected 1", count); end
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_start_n1: got %b expected 0", tx_start); end
      tick();
      n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL single_start_n2: got %b expected 1", tx_start); end
      n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h expected 41", tx_data); end
      tx_ready = 1'b0;
      repeat (10) tick();
      n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data_hold: got %h expected 41", tx_data); end
      tx_ready = 1'b1;
      repeat (6) tick();
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
      n_checks++; if (launches.size() !== 1) begin n_fail++; $display("FAIL single_launch_count: got %0d expected 1", launches.size()); end
   endtask

   task automatic test_burst();
      int seen;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(i + 1);
         tick();
      end
      wr_valid = 1'b0;
      tick();
      n_checks++; if (count !== 5'd5) begin n_fail++; $display("FAIL burst_count: got %0d expected 5", count); end
      n_checks++; if (launches.size() !== 0) begin n_fail++; $display("FAIL burst_no_start: got %0d launches expected 0", launches.size()); end
      run_tx(5, 10, seen);
      repeat (4) tick();
      n_checks++; if (seen !== 5) begin n_fail++; $display("FAIL burst_frames: got %0d expected 5", seen); end
      n_checks++; if (launches.size() !== 5) begin n_fail++; $display("FAIL burst_launches: got %0d expected 5", launches.size()); end
      for (int i = 0; i < 5 && i < launches.size(); i++) begin
         n_checks++;
         if (launches[i] !== 8'(i + 1)) begin
            n_fail++; $display("FAIL burst_order[%0d]: got %h expected %h", i, launches[i], 8'(i + 1));
         end
      end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL burst_empty: got %b expected 1", empty); end
   endtask

   task automatic test_full_overflow();
      int seen;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'h10 + 8'(i);
         tick();
      end
      wr_valid = 1'b0;
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", full); end
      n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", count); end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      run_tx(16, 3, seen);
      repeat (20) tick();
      n_checks++; if (launches.size() !== 16) begin n_fail++; $display("FAIL ovf_launches: got %0d expected 16", launches.size()); end
      for (int i = 0; i < 16 && i < launches.size(); i++) begin
         n_checks++;
         if (launches[i] !== 8'h10 + 8'(i)) begin
            n_fail++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, launches[i], 8'h10 + 8'(i));
         end
      end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
   endtask

   task automatic test_push_while_full();
      int seen;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'h30 + 8'(i);
         tick();
      end
      wr_valid = 1'b0;
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL pwf_full_before: got %b expected 1", full); end
      tx_ready = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'hAA;
      tick();
      wr_valid = 1'b0;
      n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL pwf_count: got %0d expected 16", count); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pwf_overflow: got %b expected 0", overflow); end
      n_checks++; if (tx_data !== 8'h30) begin n_fail++; $display("FAIL pwf_first: got %h expected 30", tx_data); end
      run_tx(17, 3, seen);
      repeat (20) tick();
      n_checks++; if (launches.size() !== 17) begin n_fail++; $display("FAIL pwf_launches: got %0d expected 17", launches.size()); end
      if (launches.size() == 17) begin
         n_checks++; if (launches[16] !== 8'hAA) begin n_fail++; $display("FAIL pwf_last: got %h expected aa", launches[16]); end
         n_checks++; if (launches[15] !== 8'h3F) begin n_fail++; $display("FAIL pwf_16th: got %h expected 3f", launches[15]); end
      end
   endtask

   task automatic test_busy_timeout();
      do_reset();
      tx_ready = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h55;
      tick();
      wr_data  = 8'h66;
      tick();
      wr_valid = 1'b0;
      n_checks++; if (count !== 5'd1) begin n_fail++; $display("FAIL to_count_pushpop: got %0d expected 1", count); end
      n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL to_start1: got %b expected 1", tx_start); end
      n_checks++; if (tx_data !== 8'h55) begin n_fail++; $display("FAIL to_data1: got %h expected 55", tx_data); end
      for (int k = 0; k < 5; k++) begin
         tick();
         n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL to_quiet[%0d]: got %b expected 0", k, tx_start); end
      end
      tick();
      n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL to_start2: got %b expected 1", tx_start); end
      n_checks++; if (tx_data !== 8'h66) begin n_fail++; $display("FAIL to_data2: got %h expected 66", tx_data); end
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL to_count_end: got %0d expected 0", count); end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'h71 + 8'(i);
         tick();
      end
      wr_valid = 1'b0;
      tx_ready = 1'b1;
      tick();
      n_checks++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL rmf_start: got %b expected 1", tx_start); end
      tx_ready = 1'b0;
      repeat (3) tick();
      n_checks++; if (count !== 5'd2) begin n_fail++; $display("FAIL rmf_count_before: got %0d expected 2", count); end
      rst = 1'b1;
      tick();
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL rmf_count: got %0d expected 0", count); end
      n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rmf_start_after: got %b expected 0", tx_start); end
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmf_overflow: got %b expected 0", overflow); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rmf_tx_data: got %h expected 00", tx_data); end
`ifdef UART_TX_FIFO_HWM_EN
      n_checks++; if (high_water !== 5'd0) begin n_fail++; $display("FAIL rmf_hwm: got %0d expected 0", high_water); end
`endif
      rst      = 1'b0;
      tx_ready = 1'b1;
      launches.delete();
      repeat (15) tick();
      n_checks++; if (launches.size() !== 0) begin n_fail++; $display("FAIL rmf_no_reissue: got %0d launches expected 0", launches.size()); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmf_empty: got %b expected 1", empty); end
   endtask

   initial begin
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      tx_ready = 1'b0;
`ifdef UART_TX_FIFO_HWM_EN
      hwm_clear = 1'b0;
`endif
      test_reset();
      test_single_byte();
      test_burst();
      test_full_overflow();
      test_push_while_full();
      test_busy_timeout();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
